debug_reg_dumper: RTL and testbench

//  Debug-unit side of the register-bank debug read port. After a halt, on request it drives
//  the debug read address/select into the decode stage and reads back registers 0..N_REGS-1.

---
 rtl/debug_reg_dumper_pkg.sv | 23 ++
 rtl/debug_reg_dumper_word_serializer.sv | 51 +++++
 rtl/debug_reg_dumper.sv | 135 +++++++++++++
 tb/tb_debug_reg_dumper.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_reg_dumper_pkg.sv
// Shared definitions for the debug register dumper: FSM state encodings,
// default geometry and index-width helper.
package debug_reg_dumper_pkg;

  typedef enum logic [2:0] {
    DMP_IDLE    = 3'd0,
    DMP_ADDR    = 3'd1,
    DMP_LATCH   = 3'd2,
    DMP_SEND    = 3'd3,
    DMP_WAIT_TX = 3'd4,
    DMP_DONE    = 3'd5
  } dmp_state_e;

  localparam int NB_DATA_DEF    = 32;
  localparam int NB_BYTE_DEF    = 8;
  localparam int BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE_DEF;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debug_reg_dumper_word_serializer.sv
// Word latch plus byte index: presents the latched register word one byte at
// a time, least-significant byte first.
module debug_reg_dumper_word_serializer
  import debug_reg_dumper_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_BYTE = NB_BYTE_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] word_i,
  input  logic               latch_i,
  input  logic               advance_i,
  output logic [NB_BYTE-1:0] byte_o,
  output logic               last_o
);

  localparam int BPW    = NB_DATA / NB_BYTE;
  localparam int NB_IDX = idx_width(BPW);
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(BPW - 1);

  logic [NB_DATA-1:0] word_q, word_d;
  logic [NB_IDX-1:0]  byte_q, byte_d;

  always_comb begin
    word_d = word_q;
    byte_d = byte_q;
    if (latch_i) begin
      word_d = word_i;
      byte_d = '0;
    end else if (advance_i) begin
      byte_d = byte_q + 1'b1;
    end
  end

  // NOTE: the word latch is a plain register, not a memory, and it is reset
  // because its contents are visible on o_tx_data straight out of reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      word_q <= '0;
      byte_q <= '0;
    end else begin
      word_q <= word_d;
      byte_q <= byte_d;
    end
  end

  assign byte_o = word_q[int'(byte_q)*NB_BYTE +: NB_BYTE];
  assign last_o = (byte_q == LAST_IDX);

endmodule

// File: rtl/debug_reg_dumper.sv
// Debug register dumper: walks registers 0..N_REGS-1 through the decode-stage
// debug read port and streams each word out as bytes over a TX handshake.
module debug_reg_dumper
  import debug_reg_dumper_pkg::*;
#(
  parameter int NB_DATA      = NB_DATA_DEF,
  parameter int NB_REG       = 5,
  parameter int N_REGS       = 32,
  parameter int NB_BYTE      = NB_BYTE_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_reg_data,
  input  logic               i_tx_done,
  output logic [NB_REG-1:0]  o_br_addr,
  output logic               o_br_enable,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NB_WAIT = idx_width(READ_LATENCY + 1);
  localparam logic [NB_WAIT-1:0] WAIT_MAX = NB_WAIT'(READ_LATENCY);
  localparam logic [NB_REG-1:0]  LAST_REG = NB_REG'(N_REGS - 1);

  dmp_state_e         state_q, state_d;
  logic [NB_REG-1:0]  reg_q, reg_d;
  logic [NB_WAIT-1:0] wait_q, wait_d;

  logic              last_byte;
  logic              ser_latch;
  logic              ser_advance;
  logic              busy_d;
  logic              tx_start_d;
  logic              done_d;
  logic [NB_REG-1:0] br_addr_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of process ordering.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= DMP_IDLE;
      reg_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      wait_q  <= wait_d;
    end
  end

  // NOTE: every variable gets a default before the case, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    wait_d  = wait_q;
    case (state_q)
      DMP_IDLE: begin
        if (i_start) begin
          state_d = DMP_ADDR;
          reg_d   = '0;
          wait_d  = '0;
        end
      end
      // Address is held READ_LATENCY extra cycles so the bank data has settled.
      DMP_ADDR: begin
        if (wait_q == WAIT_MAX) state_d = DMP_LATCH;
        else                    wait_d  = wait_q + 1'b1;
      end
      DMP_LATCH: state_d = DMP_SEND;
      DMP_SEND:  state_d = DMP_WAIT_TX;
      DMP_WAIT_TX: begin
        if (i_tx_done) begin
          if (!last_byte) begin
            state_d = DMP_SEND;
          end else if (reg_q == LAST_REG) begin
            state_d = DMP_DONE;
          end else begin
            state_d = DMP_ADDR;
            reg_d   = reg_q + 1'b1;
            wait_d  = '0;
          end
        end
      end
      DMP_DONE: state_d = DMP_IDLE;
      default:  state_d = DMP_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with state_q without any combinational path to the ports.
  always_comb begin
    busy_d     = (state_d != DMP_IDLE);
    br_addr_d  = busy_d ? reg_d : '0;
    tx_start_d = (state_d == DMP_SEND);
    done_d     = (state_d == DMP_DONE);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_br_addr   <= '0;
      o_br_enable <= 1'b0;
      o_busy      <= 1'b0;
      o_tx_start  <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_br_addr   <= br_addr_d;
      o_br_enable <= busy_d;
      o_busy      <= busy_d;
      o_tx_start  <= tx_start_d;
      o_done      <= done_d;
    end
  end

  assign ser_latch   = (state_q == DMP_LATCH);
  assign ser_advance = (state_q == DMP_WAIT_TX) && i_tx_done && !last_byte;

  debug_reg_dumper_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .word_i    (i_reg_data),
    .latch_i   (ser_latch),
    .advance_i (ser_advance),
    .byte_o    (o_tx_data),
    .last_o    (last_byte)
  );

endmodule

// File: tb/tb_debug_reg_dumper.sv
// Scoreboard bench for debug_reg_dumper: three instances with different read
// latency / register count, each fed by a bank model and a TX responder.
module tb_debug_reg_dumper;
  import debug_reg_dumper_pkg::*;

  localparam int N_INST = 3;

  function automatic int rl_of(input int g);
    case (g) 0: return 1; 1: return 0; default: return 2; endcase
  endfunction
  function automatic int nr_of(input int g);
    case (g) 0: return 32; 1: return 1; default: return 2; endcase
  endfunction
  function automatic int dly_of(input int g);
    case (g) 0: return 5; 1: return 1; default: return 3; endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_s      [N_INST];
  logic       start_s    [N_INST];
  logic       tx_start_a [N_INST];
  logic       done_a     [N_INST];
  logic       busy_a     [N_INST];
  logic       br_en_a    [N_INST];
  logic       real_done_a[N_INST];
  logic [7:0] tx_data_a  [N_INST];
  logic [4:0] br_addr_a  [N_INST];
  logic       inj_mode = 1'b0;

  int         n_err    = 0;
  int         n_checks = 0;
  int         bytes_seen [N_INST];
  int         done_cnt   [N_INST];
  int         start_cyc  [N_INST];
  logic       await_first[N_INST];
  logic       prev_done  [N_INST];
  logic [7:0] cur_byte   [N_INST];
  logic [7:0] reg1_bytes [4];
  logic [7:0] reg1_exp   [4] = '{8'hD1, 8'hC0, 8'hB0, 8'hA0};

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  function automatic void push_exp(input int g, input logic [7:0] b);
    case (g) 0: q0.push_back(b); 1: q1.push_back(b); default: q2.push_back(b); endcase
  endfunction
  function automatic int q_size(input int g);
    case (g) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
  endfunction
  function automatic logic [7:0] pop_exp(input int g);
    case (g) 0: return q0.pop_front(); 1: return q1.pop_front(); default: return q2.pop_front(); endcase
  endfunction
  function automatic void q_clear(input int g);
    case (g) 0: q0.delete(); 1: q1.delete(); default: q2.delete(); endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < N_INST; g++) begin : g_inst
    localparam int RL = rl_of(g);
    localparam int NR = nr_of(g);

    logic        tx_done;
    logic        real_done = 1'b0;
    logic        ghost     = 1'b0;
    logic [31:0] bank_f, pipe1, pipe2, reg_data;
    logic [4:0]  br_addr;
    logic        br_en, tx_start, busy, done;
    logic [7:0]  tx_data;

    debug_reg_dumper #(
      .NB_DATA      (32),
      .NB_REG       (5),
      .N_REGS       (NR),
      .NB_BYTE      (8),
      .READ_LATENCY (RL)
    ) dut (
      .i_clock     (clk),
      .i_reset     (rst_s[g]),
      .i_start     (start_s[g]),
      .i_reg_data  (reg_data),
      .i_tx_done   (tx_done),
      .o_br_addr   (br_addr),
      .o_br_enable (br_en),
      .o_tx_data   (tx_data),
      .o_tx_start  (tx_start),
      .o_busy      (busy),
      .o_done      (done)
    );

    // Bank model: reg[i] = A0B0C0D0 + i, visible RL cycles after the address.
    assign bank_f = br_en ? (32'hA0B0C0D0 + {27'd0, br_addr}) : 32'hDEADBEEF;
    always @(posedge clk) begin
      pipe1 <= bank_f;
      pipe2 <= pipe1;
    end
    assign reg_data = (RL == 0) ? bank_f : (RL == 1) ? pipe1 : pipe2;

    assign tx_done        = real_done | ghost;
    assign tx_start_a[g]  = tx_start;
    assign done_a[g]      = done;
    assign busy_a[g]      = busy;
    assign br_en_a[g]     = br_en;
    assign tx_data_a[g]   = tx_data;
    assign br_addr_a[g]   = br_addr;
    assign real_done_a[g] = real_done;

    // TX responder: one-cycle done pulse dly_of(g) cycles after each start.
    always begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        repeat (dly_of(g)) begin @(posedge clk); #1; end
        real_done = 1'b1;
        @(posedge clk); #1;
        real_done = 1'b0;
      end
    end

    // Stray done pulse in the cycle after each real one (next SEND or ADDR).
    always begin
      @(negedge clk);
      if (real_done && inj_mode && g == 0) begin
        @(posedge clk); #1;
        ghost = 1'b1;
        @(posedge clk); #1;
        ghost = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every byte handshake.
  always @(negedge clk) begin
    for (int g = 0; g < N_INST; g++) begin
      if (tx_start_a[g] === 1'b1) begin
        if (q_size(g) == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_byte: inst %0d got %h, expected no byte", g, tx_data_a[g]);
        end else begin
          check($sformatf("tx_byte[%0d]", g), {24'd0, tx_data_a[g]}, {24'd0, pop_exp(g)});
        end
        if (await_first[g]) begin
          check($sformatf("first_latency[%0d]", g), cyc - start_cyc[g], rl_of(g) + 3);
          await_first[g] = 1'b0;
        end
        if (g == 0 && bytes_seen[0] >= 4 && bytes_seen[0] < 8)
          reg1_bytes[bytes_seen[0] - 4] = tx_data_a[0];
        cur_byte[g] = tx_data_a[g];
        bytes_seen[g]++;
      end
      if (real_done_a[g] && busy_a[g] === 1'b1) begin
        check($sformatf("tx_stable[%0d]", g), {24'd0, tx_data_a[g]}, {24'd0, cur_byte[g]});
        check($sformatf("br_en_in_tx[%0d]", g), {31'd0, br_en_a[g]}, 32'd1);
      end
      if (done_a[g] === 1'b1) begin
        done_cnt[g]++;
        check($sformatf("queue_empty_at_done[%0d]", g), q_size(g), 0);
      end
      if (prev_done[g] === 1'b1)
        check($sformatf("idle_after_done[%0d]", g), {30'd0, br_en_a[g], busy_a[g]}, 32'd0);
      if (g == 1 && busy_a[1] === 1'b1)
        check("n1_addr_zero", {27'd0, br_addr_a[1]}, 32'd0);
      prev_done[g] = done_a[g];
    end
  end

  task automatic start_dump(input int g);
    for (int r = 0; r < nr_of(g); r++)
      for (int b = 0; b < BYTES_PER_WORD; b++)
        push_exp(g, 8'((32'hA0B0C0D0 + r) >> (8 * b)));
    start_cyc[g]   = cyc;
    await_first[g] = 1'b1;
    start_s[g]     = 1'b1;
    @(posedge clk); #1;
    start_s[g]     = 1'b0;
  endtask

  task automatic wait_done(input int g, input int target, input int budget);
    int n = 0;
    while (done_cnt[g] < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("done_reached[%0d]", g), done_cnt[g], target);
  endtask

  task automatic pulse_start(input int g);
    start_s[g] = 1'b1;
    @(posedge clk); #1;
    start_s[g] = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < N_INST; g++) begin
      rst_s[g]       = 1'b1;
      start_s[g]     = 1'b0;
      bytes_seen[g]  = 0;
      done_cnt[g]    = 0;
      start_cyc[g]   = 0;
      await_first[g] = 1'b0;
      prev_done[g]   = 1'b0;
      cur_byte[g]    = 8'h00;
    end

    // Reset state of every instance.
    repeat (3) @(negedge clk);
    for (int g = 0; g < N_INST; g++)
      check($sformatf("reset_outputs[%0d]", g),
            {12'd0, busy_a[g], br_en_a[g], tx_start_a[g], done_a[g], br_addr_a[g], tx_data_a[g]},
            32'd0);
    @(posedge clk); #1;
    for (int g = 0; g < N_INST; g++) rst_s[g] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Single register, immediate tx_done; then READ_LATENCY=2 over two registers.
    start_dump(1);
    wait_done(1, 1, 200);
    check("bytes_n1", bytes_seen[1], 4);
    start_dump(2);
    wait_done(2, 1, 400);
    check("bytes_rl2", bytes_seen[2], 8);

    // Full dump with 5-cycle TX.
    start_dump(0);
    wait_done(0, 1, 3000);
    check("bytes_full", bytes_seen[0], 128);
    for (int i = 0; i < 4; i++) check($sformatf("reg1_byte%0d", i), {24'd0, reg1_bytes[i]}, {24'd0, reg1_exp[i]});
    repeat (5) begin @(posedge clk); #1; end
    check("single_done", done_cnt[0], 1);

    // Stray starts and stray tx_done pulses during a dump.
    inj_mode      = 1'b1;
    bytes_seen[0] = 0;
    start_dump(0);
    repeat (150) begin @(posedge clk); #1; end
    pulse_start(0);
    repeat (300) begin @(posedge clk); #1; end
    pulse_start(0);
    wait_done(0, 2, 4000);
    inj_mode = 1'b0;
    check("bytes_with_noise", bytes_seen[0], 128);
    repeat (5) begin @(posedge clk); #1; end
    check("single_done_noise", done_cnt[0], 2);

    // Abort on reg 7, byte 2, then restart from reg 0.
    bytes_seen[0] = 0;
    start_dump(0);
    for (int n = 0; n < 1500 && bytes_seen[0] < 31; n++) begin @(posedge clk); #1; end
    check("reach_reg7_byte2", bytes_seen[0], 31);
    rst_s[0] = 1'b1;
    q_clear(0);
    @(posedge clk);
    @(negedge clk);
    check("abort_outputs",
          {12'd0, busy_a[0], br_en_a[0], tx_start_a[0], done_a[0], br_addr_a[0], tx_data_a[0]},
          32'd0);
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("no_done_on_abort", done_cnt[0], 2);
    bytes_seen[0] = 0;
    start_dump(0);
    wait_done(0, 3, 3000);
    check("bytes_after_abort", bytes_seen[0], 128);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
